// File: rtl/truth_table_sequencer_pkg.sv
// Shared encodings and sizing helpers for the truth-table sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tt_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  // Width of a counter that must reach SETTLE_CYCLES without wrapping; never below 1.
  function automatic int unsigned cnt_width(input int unsigned settle_cycles);
    int unsigned w;
    w = $clog2(settle_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Per-vector settle counter: cleared on load, advances while enabled, flags the last settle clock.
// Latency: expire is combinational from the counter register.
// Backpressure: none; driven purely by the sequencer FSM.
module settle_timer
  import tt_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = cnt_width(SETTLE_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Load wins over count so a fresh vector always starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == CW'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps every input vector into a logic block, samples its output and scores it against EXPECTED.
// Latency: done pulses 2**N_IN*(SETTLE_CYCLES+1) clocks after the accepted start edge.
// Backpressure: start is ignored unless idle; abort drops a running sweep without a done pulse.
module truth_table_sequencer
  import tt_seq_pkg::*;
#(
  parameter int unsigned          N_IN          = 2,
  parameter int unsigned          SETTLE_CYCLES = 4,
  parameter logic [2**N_IN-1:0]   EXPECTED      = 4'b1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                dut_out,
  output logic [N_IN-1:0]     in_vec,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [2**N_IN-1:0]  observed,
  output logic [N_IN:0]       mismatch_count
);

  localparam logic [N_IN-1:0] LAST_IDX = '1;

  state_t              state_q, state_d;
  logic [N_IN-1:0]     idx_q, idx_d;
  logic [N_IN-1:0]     in_vec_q, in_vec_d;
  logic [2**N_IN-1:0]  observed_q, observed_d;
  logic [N_IN:0]       mismatch_q, mismatch_d;
  logic                pass_q, pass_d;

  logic start_acc;
  logic abort_run;
  logic sample_go;
  logic last_vec;
  logic timer_load;
  logic timer_expire;
  logic miss;

  assign start_acc  = (state_q == ST_IDLE) && start;
  assign abort_run  = ((state_q == ST_SETTLE) || (state_q == ST_SAMPLE)) && abort;
  assign sample_go  = (state_q == ST_SAMPLE) && !abort;
  assign last_vec   = (idx_q == LAST_IDX);
  assign timer_load = start_acc || (sample_go && !last_vec);
  assign miss       = (dut_out != EXPECTED[idx_q]);

  settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .en     (state_q == ST_SETTLE),
    .expire (timer_expire)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: abort outranks every transition while a sweep is running.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (abort)             state_d = ST_IDLE;
        else if (timer_expire) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (abort)         state_d = ST_IDLE;
        else if (last_vec) state_d = ST_DONE;
        else               state_d = ST_SETTLE;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded straight from the state; busy and done are mutually exclusive.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_SETTLE: busy = 1'b1;
      ST_SAMPLE: busy = 1'b1;
      ST_DONE:   done = 1'b1;
      default:   ;
    endcase
  end

  // Index, stimulus and scoreboard updates; pass uses the count including the final sample.
  always_comb begin
    idx_d      = idx_q;
    in_vec_d   = in_vec_q;
    observed_d = observed_q;
    mismatch_d = mismatch_q;
    pass_d     = pass_q;
    if (start_acc) begin
      idx_d      = '0;
      in_vec_d   = '0;
      observed_d = '0;
      mismatch_d = '0;
      pass_d     = 1'b0;
    end else if (abort_run) begin
      in_vec_d = '0;
    end else if (sample_go) begin
      observed_d[idx_q] = dut_out;
      mismatch_d        = mismatch_q + {{N_IN{1'b0}}, miss};
      if (last_vec) begin
        pass_d = (mismatch_d == '0);
      end else begin
        idx_d    = idx_q + N_IN'(1);
        in_vec_d = idx_q + N_IN'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      in_vec_q   <= '0;
      observed_q <= '0;
      mismatch_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      in_vec_q   <= in_vec_d;
      observed_q <= observed_d;
      mismatch_q <= mismatch_d;
      pass_q     <= pass_d;
    end
  end

  assign in_vec         = in_vec_q;
  assign observed       = observed_q;
  assign mismatch_count = mismatch_q;
  assign pass           = pass_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for the truth-table sequencer: 2-input AND / tied-high targets and a 3-input instance.
// Latency: cycle numbers below count clock edges after the accepted start edge.
// Backpressure: start-held, abort and mid-sweep reset scenarios included.
module tb_truth_table_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start, abort, mode;
  logic       dut_out;
  logic [1:0] in_vec;
  logic       busy, done, pass;
  logic [3:0] observed;
  logic [2:0] mismatch_count;

  logic       start_b;
  logic       dut_out_b;
  logic [2:0] in_vec_b;
  logic       busy_b, done_b, pass_b;
  logic [7:0] observed_b;
  logic [3:0] mismatch_count_b;

  int n_chk  = 0;
  int n_pass = 0;
  int ndone;

  always #5 clk = ~clk;

  assign dut_out   = mode ? 1'b1 : (&in_vec);
  assign dut_out_b = &in_vec_b;

  truth_table_sequencer #(.N_IN(2), .SETTLE_CYCLES(4), .EXPECTED(4'b1000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_out(dut_out),
    .in_vec(in_vec), .busy(busy), .done(done), .pass(pass),
    .observed(observed), .mismatch_count(mismatch_count)
  );

  truth_table_sequencer #(.N_IN(3), .SETTLE_CYCLES(1), .EXPECTED(8'h80)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0), .dut_out(dut_out_b),
    .in_vec(in_vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .observed(observed_b), .mismatch_count(mismatch_count_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    start = 0; abort = 0; mode = 0; start_b = 0;

    // Reset state
    #2;
    check("rst_invec", in_vec, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_observed", observed, 0);
    check("rst_mismatch", mismatch_count, 0);
    check("rst_b_observed", observed_b, 0);
    #10 rst_n = 1;
    tick();

    // 1: AND target, full sweep
    mode = 0; start = 1; tick(); start = 0;
    check("t1_invec0", in_vec, 0);
    check("t1_busy0", busy, 1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k < 20) check("t1_invec", in_vec, k / 5);
      check("t1_busy", busy, (k < 20));
      check("t1_done", done, (k == 20));
    end
    check("t1_observed", observed, 4'b1000);
    check("t1_mismatch", mismatch_count, 0);
    check("t1_pass", pass, 1);
    tick();
    check("t1_done_gone", done, 0);
    check("t1_idle", busy, 0);
    check("t1_pass_held", pass, 1);

    // 2: output tied high
    mode = 1; start = 1; tick(); start = 0;
    check("t2_pass_clr", pass, 0);
    check("t2_obs_clr", observed, 0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("t2_done", done, (k == 20));
    end
    check("t2_observed", observed, 4'b1111);
    check("t2_mismatch", mismatch_count, 3);
    check("t2_pass", pass, 0);
    tick();

    // 3: start held for 30 cycles
    mode = 0; start = 1; tick();
    ndone = 0;
    for (int k = 1; k <= 29; k++) begin
      tick();
      if (done) ndone++;
      if (k == 20) check("t3_done20", done, 1);
      if (k == 21) check("t3_idle21", busy, 0);
      if (k == 21) check("t3_nodone21", done, 0);
      if (k == 22) check("t3_restart22", busy, 1);
    end
    start = 0;
    check("t3_one_done", ndone, 1);
    abort = 1; tick(); abort = 0;
    check("t3_abort_idle", busy, 0);

    // 4: abort while vector 1 settles
    mode = 1; start = 1; tick(); start = 0;
    for (int k = 1; k <= 7; k++) tick();
    check("t4_invec1", in_vec, 1);
    abort = 1; tick(); abort = 0;
    check("t4_busy", busy, 0);
    check("t4_invec", in_vec, 0);
    check("t4_done", done, 0);
    check("t4_observed", observed, 4'b0001);
    check("t4_mismatch", mismatch_count, 1);
    check("t4_pass", pass, 0);
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done) ndone++;
    end
    check("t4_no_done", ndone, 0);
    check("t4_stay_idle", busy, 0);

    // 5: asynchronous reset during a SAMPLE
    mode = 1; start = 1; tick(); start = 0;
    for (int k = 1; k <= 9; k++) tick();
    check("t5_pre_invec", in_vec, 1);
    check("t5_pre_observed", observed, 4'b0001);
    #2 rst_n = 0;
    #1;
    check("t5_rst_invec", in_vec, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_observed", observed, 0);
    check("t5_rst_mismatch", mismatch_count, 0);
    #3 rst_n = 1;
    tick();
    check("t5_idle", busy, 0);
    mode = 0; start = 1; tick(); start = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("t5_done", done, (k == 20));
    end
    check("t5_observed", observed, 4'b1000);
    check("t5_pass", pass, 1);
    check("t5_mismatch", mismatch_count, 0);

    // 6: 3-input AND, one settle clock
    start_b = 1; tick(); start_b = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16) check("t6_invec", in_vec_b, k / 2);
      check("t6_busy", busy_b, (k < 16));
      check("t6_done", done_b, (k == 16));
    end
    check("t6_observed", observed_b, 8'h80);
    check("t6_mismatch", mismatch_count_b, 0);
    check("t6_pass", pass_b, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
